mesi_cbus_snoop: RTL and testbench
==================================

// Module: mesi_cbus_snoop
// PURPOSE
//  Per-CPU coherence-bus responder, directly downstream of the MESI intersection controller.
//  - Consumes one coherence-bus command/address and returns the matching cbus_ack.
//  - Keeps a direct-mapped MESI line-state table for its CPU's cache.
//  - Snoops: writes back Modified lines, then downgrades or invalidates them.
//  - Enables: grants the local CPU its pending access and waits for completion.
//  - One instance per CPU (4 in the system).
// PARAMETERS
//  ADDR_WIDTH      32  address width, shared with the coherence bus
//  CBUS_CMD_WIDTH  3   coherence command width
//  OFFSET_WIDTH    4   log2 bytes per line; low address bits ignored
//  INDEX_WIDTH     4   log2 table entries (16 lines)
//  WB_CNT_WIDTH    16  writeback statistic counter width
// PORTS
//  clk          in   1               system clock, rising edge
//  rst_n        in   1               asynchronous active-low reset
//  cbus_addr_i  in   ADDR_WIDTH      coherence bus address
//  cbus_cmd_i   in   CBUS_CMD_WIDTH  coherence bus command
//  cbus_ack_o   out  1               coherence bus acknowledge
//  wb_req_o     out  1               writeback request to memory
//  wb_addr_o    out  ADDR_WIDTH      writeback line address, offset bits zeroed
//  wb_ack_i     in   1               writeback done
//  cpu_en_wr_o  out  1               1-cycle pulse: CPU may perform its write
//  cpu_en_rd_o  out  1               1-cycle pulse: CPU may perform its read
//  cpu_addr_o   out  ADDR_WIDTH      address of the enabled access
//  cpu_done_i   in   1               CPU access complete
//  wb_cnt_o     out  WB_CNT_WIDTH    saturating count of completed writebacks
// BEHAVIOUR
//  Command codes: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4; 5..7 reserved.
//  Line states:   I=0, S=1, E=2, M=3.
//  Reset (async, rst_n=0):
//   - all outputs 0; FSM -> IDLE; every table entry -> I, tag 0; wb_cnt_o=0.
//  FSM states: IDLE, LOOKUP, WB_REQ, CPU_EN, CPU_WAIT, ACK.
//  IDLE:
//   - on cbus_cmd_i!=NOP, latch cmd and addr -> LOOKUP.
//   - cbus inputs are ignored in every state except IDLE and ACK.
//  LOOKUP (1 cycle): read entry[addr index]; hit = tag match && state!=I.
//   - WR_SNOOP or RD_SNOOP, hit in M -> WB_REQ.
//   - other snoops -> ACK.
//   - EN_WR or EN_RD -> CPU_EN.
//   - reserved code -> ACK; no table change.
//  WB_REQ:
//   - wb_req_o=1, wb_addr_o held stable until wb_ack_i=1 sampled.
//   - on wb_ack_i: wb_cnt_o+1, saturating at all-ones -> ACK.
//   - wb_ack_i outside WB_REQ is ignored.
//  CPU_EN (1 cycle): pulse cpu_en_wr_o or cpu_en_rd_o; cpu_addr_o=latched addr -> CPU_WAIT.
//  CPU_WAIT:
//   - cpu_addr_o held; on cpu_done_i -> ACK.
//   - cpu_done_i is sampled only in CPU_WAIT, so the earliest counted done is the cycle after the pulse.
//  Table update, one write on the transition into ACK:
//   - WR_SNOOP hit -> I.
//   - RD_SNOOP hit: M or E -> S; S stays S.
//   - EN_WR -> tag=addr tag, M; overwrites any previous line.
//   - EN_RD -> tag=addr tag, S.
//   - snoop miss -> no change.
//  ACK:
//   - cbus_ack_o=1 while in ACK.
//   - when cbus_cmd_i==NOP is sampled -> IDLE with ack 0 next cycle (4-phase).
//   - the next command is accepted only from IDLE.
//  Latency, IDLE snoop miss: cmd seen at cycle t, ack high from t+2.
//  Latency, M hit with wb_ack_i at first WB_REQ cycle: ack high from t+3.
// STRUCTURE
//  Package mesi_pkg: command-code localparams, line-state enum, FSM state enum.
//  Sub-module mesi_line_table: tag/state array with 1 read port (comb) and 1 write port (sync).
//  Top module: FSM, address/command latch, writeback counter.
// TESTING
//  1. Snoop miss: WR_SNOOP 0x100 with table empty -> ack at t+2, no wb_req_o, entry stays I.
//  2. EN_WR 0x230, then cpu_done_i 3 cycles after the pulse -> ack; entry[3] = tag 0x2, M.
//  3. After (2), RD_SNOOP 0x230 -> wb_req_o, wb_addr_o=0x230; wb_ack_i after 5 cycles -> ack;
//     entry -> S; wb_cnt_o=1.
//  4. After (3), WR_SNOOP 0x23C (same line) -> no writeback, ack at t+2, entry -> I.
//  5. cbus_cmd_i held non-NOP for 4 cycles after ack -> ack stays high; exactly one table update;
//     returns to IDLE only after NOP.
//  6. rst_n low in WB_REQ -> wb_req_o=0 immediately, all lines I; reserved cmd 6 -> ack, no change.

Source files
------------

// File: rtl/mesi_pkg.sv
// Shared definitions for the per-CPU MESI coherence-bus responder:
// command codes, line states and the responder FSM state encoding.
package mesi_pkg;

  localparam int unsigned CMD_NOP      = 0;
  localparam int unsigned CMD_WR_SNOOP = 1;
  localparam int unsigned CMD_RD_SNOOP = 2;
  localparam int unsigned CMD_EN_WR    = 3;
  localparam int unsigned CMD_EN_RD    = 4;

  typedef enum logic [1:0] {
    LS_I = 2'd0,
    LS_S = 2'd1,
    LS_E = 2'd2,
    LS_M = 2'd3
  } line_state_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_WB_REQ   = 3'd2,
    ST_CPU_EN   = 3'd3,
    ST_CPU_WAIT = 3'd4,
    ST_ACK      = 3'd5
  } fsm_state_e;

endpackage

// File: rtl/mesi_line_table.sv
// Direct-mapped tag/MESI-state table: one combinational read port and one
// synchronous write port. Reset invalidates every line and clears its tag.
module mesi_line_table
  import mesi_pkg::*;
#(
  parameter int TAG_WIDTH   = 24,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] i_rd_idx,
  output logic [TAG_WIDTH-1:0]   o_rd_tag,
  output line_state_e            o_rd_state,
  input  logic                   i_wr_en,
  input  logic [INDEX_WIDTH-1:0] i_wr_idx,
  input  logic [TAG_WIDTH-1:0]   i_wr_tag,
  input  line_state_e            i_wr_state
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [TAG_WIDTH-1:0] r_tag   [DEPTH];
  line_state_e          r_state [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]   <= '0;
        r_state[i] <= LS_I;
      end
    end else if (i_wr_en) begin
      r_tag[i_wr_idx]   <= i_wr_tag;
      r_state[i_wr_idx] <= i_wr_state;
    end
  end

  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_state = r_state[i_rd_idx];

endmodule

// File: rtl/mesi_cbus_snoop.sv
// Per-CPU coherence-bus responder: latches one bus command, snoops or enables
// the local CPU, writes back Modified lines, and answers with a 4-phase ack.
module mesi_cbus_snoop
  import mesi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int OFFSET_WIDTH   = 4,
  parameter int INDEX_WIDTH    = 4,
  parameter int WB_CNT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  output logic                      cbus_ack_o,
  output logic                      wb_req_o,
  output logic [ADDR_WIDTH-1:0]     wb_addr_o,
  input  logic                      wb_ack_i,
  output logic                      cpu_en_wr_o,
  output logic                      cpu_en_rd_o,
  output logic [ADDR_WIDTH-1:0]     cpu_addr_o,
  input  logic                      cpu_done_i,
  output logic [WB_CNT_WIDTH-1:0]   wb_cnt_o,
  output fsm_state_e                dbg_state_o
);

  // Handshakes: the bus command is a 4-phase req/ack (command held non-NOP
  // until ack, ack dropped the cycle after NOP is seen); wb_req_o stays high
  // with a stable address until wb_ack_i is sampled; cpu_en_* is a one-cycle
  // grant and cpu_done_i is only honoured while waiting for the CPU.

  localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_WIDTH - INDEX_WIDTH;

  fsm_state_e                r_state, w_next;
  logic [CBUS_CMD_WIDTH-1:0] r_cmd;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [WB_CNT_WIDTH-1:0]   r_wb_cnt;

  logic [INDEX_WIDTH-1:0] w_idx;
  logic [TAG_WIDTH-1:0]   w_tag, w_rd_tag, w_wr_tag;
  line_state_e            w_rd_state, w_wr_state;
  logic                   w_hit, w_is_snoop, w_is_en, w_wr_en;

  assign w_idx      = r_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_tag      = r_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign w_hit      = (w_rd_state != LS_I) && (w_rd_tag == w_tag);
  assign w_is_snoop = (r_cmd == CBUS_CMD_WIDTH'(CMD_WR_SNOOP)) ||
                      (r_cmd == CBUS_CMD_WIDTH'(CMD_RD_SNOOP));
  assign w_is_en    = (r_cmd == CBUS_CMD_WIDTH'(CMD_EN_WR)) ||
                      (r_cmd == CBUS_CMD_WIDTH'(CMD_EN_RD));

  mesi_line_table #(
    .TAG_WIDTH  (TAG_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd_idx  (w_idx),
    .o_rd_tag  (w_rd_tag),
    .o_rd_state(w_rd_state),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_idx),
    .i_wr_tag  (w_wr_tag),
    .i_wr_state(w_wr_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cmd    <= '0;
      r_addr   <= '0;
      r_wb_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && cbus_cmd_i != CBUS_CMD_WIDTH'(CMD_NOP)) begin
        r_cmd  <= cbus_cmd_i;
        r_addr <= cbus_addr_i;
      end
      if (r_state == ST_WB_REQ && wb_ack_i && r_wb_cnt != '1) begin
        r_wb_cnt <= r_wb_cnt + WB_CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (cbus_cmd_i != CBUS_CMD_WIDTH'(CMD_NOP)) w_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (w_is_en)                                      w_next = ST_CPU_EN;
        else if (w_is_snoop && w_hit && w_rd_state == LS_M) w_next = ST_WB_REQ;
        else                                              w_next = ST_ACK;
      end
      ST_WB_REQ:   if (wb_ack_i)   w_next = ST_ACK;
      ST_CPU_EN:   w_next = ST_CPU_WAIT;
      ST_CPU_WAIT: if (cpu_done_i) w_next = ST_ACK;
      ST_ACK:      if (cbus_cmd_i == CBUS_CMD_WIDTH'(CMD_NOP)) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // The line is read from the latched address, which is stable for the whole
  // transaction, so the single table write happens on entry to ACK.
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_tag   = w_rd_tag;
    w_wr_state = w_rd_state;
    if (w_next == ST_ACK && r_state != ST_ACK) begin
      case (r_cmd)
        CBUS_CMD_WIDTH'(CMD_WR_SNOOP): if (w_hit) begin
          w_wr_en    = 1'b1;
          w_wr_state = LS_I;
        end
        CBUS_CMD_WIDTH'(CMD_RD_SNOOP): if (w_hit) begin
          w_wr_en    = 1'b1;
          w_wr_state = LS_S;
        end
        CBUS_CMD_WIDTH'(CMD_EN_WR): begin
          w_wr_en    = 1'b1;
          w_wr_tag   = w_tag;
          w_wr_state = LS_M;
        end
        CBUS_CMD_WIDTH'(CMD_EN_RD): begin
          w_wr_en    = 1'b1;
          w_wr_tag   = w_tag;
          w_wr_state = LS_S;
        end
        default: w_wr_en = 1'b0;
      endcase
    end
  end

  assign cbus_ack_o  = (r_state == ST_ACK);
  assign wb_req_o    = (r_state == ST_WB_REQ);
  assign wb_addr_o   = wb_req_o ? {r_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}} : '0;
  assign cpu_en_wr_o = (r_state == ST_CPU_EN) && (r_cmd == CBUS_CMD_WIDTH'(CMD_EN_WR));
  assign cpu_en_rd_o = (r_state == ST_CPU_EN) && (r_cmd == CBUS_CMD_WIDTH'(CMD_EN_RD));
  assign cpu_addr_o  = (r_state == ST_CPU_EN || r_state == ST_CPU_WAIT) ? r_addr : '0;
  assign wb_cnt_o    = r_wb_cnt;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mesi_cbus_snoop.sv
// Directed plus randomized bench for mesi_cbus_snoop against a line-table
// reference model built from the MESI snoop/enable rules.
module tb_mesi_cbus_snoop;
  import mesi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cbus_addr_i;
  logic [2:0]  cbus_cmd_i;
  logic        cbus_ack_o;
  logic        wb_req_o;
  logic [31:0] wb_addr_o;
  logic        wb_ack_i;
  logic        cpu_en_wr_o;
  logic        cpu_en_rd_o;
  logic [31:0] cpu_addr_o;
  logic        cpu_done_i;
  logic [15:0] wb_cnt_o;
  fsm_state_e  dbg_state;

  int errors = 0;
  int checks = 0;

  // reference model: line state (I=0,S=1,E=2,M=3), tag, writeback count
  int          m_st  [16];
  logic [23:0] m_tag [16];
  int          m_cnt;

  mesi_cbus_snoop dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cbus_addr_i(cbus_addr_i),
    .cbus_cmd_i (cbus_cmd_i),
    .cbus_ack_o (cbus_ack_o),
    .wb_req_o   (wb_req_o),
    .wb_addr_o  (wb_addr_o),
    .wb_ack_i   (wb_ack_i),
    .cpu_en_wr_o(cpu_en_wr_o),
    .cpu_en_rd_o(cpu_en_rd_o),
    .cpu_addr_o (cpu_addr_o),
    .cpu_done_i (cpu_done_i),
    .wb_cnt_o   (wb_cnt_o),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_st[i]  = 0;
      m_tag[i] = '0;
    end
    m_cnt = 0;
  endtask

  task automatic chk_line(input string tag, input int idx);
    logic [1:0]  st;
    logic [23:0] tg;
    st = dut.u_table.r_state[idx];
    tg = dut.u_table.r_tag[idx];
    chk({tag, "_state"}, st, m_st[idx]);
    if (m_st[idx] != 0) chk({tag, "_tag"}, tg, m_tag[idx]);
  endtask

  // One full bus transaction from IDLE back to IDLE, with noise on every
  // input that the responder must ignore while busy.
  task automatic run_txn(input string tag, input logic [2:0] cmd, input logic [31:0] addr,
                         input int wb_delay, input int done_delay, input int hold);
    int          idx, cyc, wb_cyc, pulse_cyc, nwr, nrd, exp_lat;
    logic [23:0] tg;
    bit          hit, exp_wb, saw_wb, wb_addr_ok, cpu_addr_ok, got_ack;
    idx     = int'(addr[7:4]);
    tg      = addr[31:8];
    hit     = (m_st[idx] != 0) && (m_tag[idx] == tg);
    exp_wb  = (cmd == 1 || cmd == 2) && hit && (m_st[idx] == 3);
    exp_lat = exp_wb ? 3 + wb_delay : (cmd == 3 || cmd == 4) ? 3 + done_delay : 2;

    cbus_cmd_i = cmd;
    cbus_addr_i = addr;
    wb_ack_i = 1'b0;
    cpu_done_i = 1'b0;
    cyc = 0; wb_cyc = 0; pulse_cyc = -1; nwr = 0; nrd = 0;
    saw_wb = 0; wb_addr_ok = 1; cpu_addr_ok = 1; got_ack = 0;
    while (!got_ack && cyc <= 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cbus_ack_o) begin
        got_ack = 1;
      end else begin
        cbus_cmd_i  = 3'($urandom_range(0, 7));
        cbus_addr_i = $urandom;
        wb_ack_i    = 1'b0;
        if (wb_req_o) begin
          saw_wb = 1;
          if (wb_addr_o !== {addr[31:4], 4'h0}) wb_addr_ok = 0;
          if (wb_cyc == wb_delay) wb_ack_i = 1'b1;
          wb_cyc++;
        end else begin
          wb_ack_i = 1'($urandom_range(0, 1));
        end
        if (cpu_en_wr_o) nwr++;
        if (cpu_en_rd_o) nrd++;
        if (cpu_en_wr_o || cpu_en_rd_o) begin
          pulse_cyc = cyc;
          if (cpu_addr_o !== addr) cpu_addr_ok = 0;
          cpu_done_i = 1'($urandom_range(0, 1));
        end else if (pulse_cyc >= 0) begin
          if (cpu_addr_o !== addr) cpu_addr_ok = 0;
          cpu_done_i = (cyc - pulse_cyc == done_delay);
        end else begin
          cpu_done_i = 1'($urandom_range(0, 1));
        end
      end
    end
    chk({tag, "_ack_seen"}, got_ack, 1'b1);
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_wb_req"}, saw_wb, exp_wb);
    if (exp_wb) chk({tag, "_wb_addr"}, wb_addr_ok, 1'b1);
    chk({tag, "_en_wr_pulses"}, 64'(nwr), (cmd == 3) ? 64'd1 : 64'd0);
    chk({tag, "_en_rd_pulses"}, 64'(nrd), (cmd == 4) ? 64'd1 : 64'd0);
    if (cmd == 3 || cmd == 4) chk({tag, "_cpu_addr"}, cpu_addr_ok, 1'b1);

    wb_ack_i = 1'b0;
    cpu_done_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      cbus_cmd_i  = 3'($urandom_range(1, 7));
      cbus_addr_i = $urandom;
      @(posedge clk); #1;
      chk({tag, "_ack_hold"}, cbus_ack_o, 1'b1);
    end
    cbus_cmd_i = 3'd0;
    @(posedge clk); #1;
    chk({tag, "_ack_drop"}, cbus_ack_o, 1'b0);

    if (cmd == 1 && hit) m_st[idx] = 0;
    else if (cmd == 2 && hit) m_st[idx] = 1;
    else if (cmd == 3) begin m_tag[idx] = tg; m_st[idx] = 3; end
    else if (cmd == 4) begin m_tag[idx] = tg; m_st[idx] = 1; end
    if (exp_wb && m_cnt < 65535) m_cnt++;
    chk_line(tag, idx);
    chk({tag, "_wb_cnt"}, wb_cnt_o, 64'(m_cnt));
  endtask

  initial begin
    int          k;
    logic [31:0] ra;
    bit          all_inv;
    rst_n = 1'b0;
    cbus_cmd_i = '0; cbus_addr_i = '0; wb_ack_i = 1'b0; cpu_done_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {cbus_ack_o, wb_req_o, cpu_en_wr_o, cpu_en_rd_o}, 4'b0);
    chk("rst_addrs", {wb_addr_o, cpu_addr_o}, 64'd0);
    chk("rst_wb_cnt", wb_cnt_o, 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn("miss_wr_snoop", 3'd1, 32'h100, 0, 0, 0);
    chk_line("miss_idx0", 0);
    run_txn("en_wr", 3'd3, 32'h230, 0, 3, 0);
    run_txn("rd_snoop_m", 3'd2, 32'h230, 5, 0, 0);
    run_txn("wr_snoop_s", 3'd1, 32'h23C, 0, 0, 0);
    run_txn("en_rd_hold", 3'd4, 32'h450, 0, 1, 4);
    run_txn("rd_snoop_s_hold", 3'd2, 32'h45F, 0, 0, 3);

    // reset while a writeback is outstanding
    run_txn("en_wr_pre_rst", 3'd3, 32'h5A0, 0, 2, 0);
    cbus_cmd_i = 3'd2;
    cbus_addr_i = 32'h5A4;
    k = 0;
    while (!wb_req_o && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_mid_wb_reached", wb_req_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wb_req", wb_req_o, 1'b0);
    chk("rst_mid_ack", cbus_ack_o, 1'b0);
    chk("rst_mid_wb_cnt", wb_cnt_o, 16'd0);
    all_inv = 1;
    for (int i = 0; i < 16; i++) if (dut.u_table.r_state[i] != LS_I) all_inv = 0;
    chk("rst_mid_all_invalid", all_inv, 1'b1);
    model_reset();
    cbus_cmd_i = 3'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn("en_wr_after_rst", 3'd3, 32'h130, 0, 1, 0);
    run_txn("reserved6", 3'd6, 32'h130, 0, 0, 1);
    run_txn("reserved7", 3'd7, 32'h230, 0, 0, 0);
    run_txn("rd_snoop_m2", 3'd2, 32'h13C, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      ra = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4) |
           32'($urandom_range(0, 15));
      run_txn("rand", 3'($urandom_range(1, 7)), ra, $urandom_range(0, 4),
              $urandom_range(1, 4), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
